// File: rtl/hex_display_ctrl.sv
// Memory-mapped 8-digit seven-segment display controller: DATA/MASK/CTRL registers,
// registered bus read, and a time-multiplexed active-low segment/anode driver.
module hex_display_ctrl #(
    parameter int SCAN_DIV = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [6:0]  hex_led_o,
    output logic [7:0]  hex_sel_o
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    logic [31:0]   data_reg;
    logic [7:0]    mask_reg;
    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [31:0]   rdata_reg;
    logic [6:0]    led_reg;
    logic [7:0]    sel_reg;

    logic [31:0] rdata_next;
    logic [6:0]  led_next;
    logic [7:0]  sel_next;
    logic [3:0]  nibble [8];

    logic wr_en;
    logic rd_en;
    logic ctrl_clear;

    assign wr_en      = req_i & we_i;
    assign rd_en      = req_i & ~we_i;
    assign ctrl_clear = wr_en && (addr_i[3:2] == REG_CTRL) && wdata_i[0];

    for (genvar gi = 0; gi < 8; gi++) begin : g_nibble
        assign nibble[gi] = data_reg[4*gi +: 4];
    end

    always_comb begin
        rdata_next = 32'd0;
        case (addr_i[3:2])
            REG_DATA: rdata_next = data_reg;
            REG_MASK: rdata_next = {24'd0, mask_reg};
            default:  rdata_next = 32'd0;
        endcase
    end

    // Anode stays high for the whole slot of a masked digit so every slot is equally long.
    always_comb begin
        sel_next = ~({7'd0, mask_reg[idx_reg]} << idx_reg);
        led_next = 7'h7F;
        case (nibble[idx_reg])
            4'h0: led_next = 7'h40;
            4'h1: led_next = 7'h79;
            4'h2: led_next = 7'h24;
            4'h3: led_next = 7'h30;
            4'h4: led_next = 7'h19;
            4'h5: led_next = 7'h12;
            4'h6: led_next = 7'h02;
            4'h7: led_next = 7'h78;
            4'h8: led_next = 7'h00;
            4'h9: led_next = 7'h10;
            4'hA: led_next = 7'h08;
            4'hB: led_next = 7'h03;
            4'hC: led_next = 7'h46;
            4'hD: led_next = 7'h21;
            4'hE: led_next = 7'h06;
            default: led_next = 7'h0E;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_reg  <= 32'd0;
            mask_reg  <= 8'hFF;
            cnt_reg   <= '0;
            idx_reg   <= 3'd0;
            rdata_reg <= 32'd0;
            led_reg   <= 7'h7F;
            sel_reg   <= 8'hFF;
        end else begin
            if (wr_en && addr_i[3:2] == REG_DATA) begin
                data_reg <= wdata_i;
            end
            if (wr_en && addr_i[3:2] == REG_MASK) begin
                mask_reg <= wdata_i[7:0];
            end
            if (ctrl_clear) begin
                data_reg <= 32'd0;
                mask_reg <= 8'hFF;
            end

            if (ctrl_clear) begin
                cnt_reg <= '0;
                idx_reg <= 3'd0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg <= '0;
                idx_reg <= idx_reg + 3'd1;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end

            if (rd_en) begin
                rdata_reg <= rdata_next;
            end

            led_reg <= led_next;
            sel_reg <= sel_next;
        end
    end

    assign rdata_o   = rdata_reg;
    assign hex_led_o = led_reg;
    assign hex_sel_o = sel_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with SCAN_DIV=4; the expected scan position is
// tracked by a small slot counter, segment/anode values come from hand-written tables.
module tb_hex_display_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [6:0]  hex_led;
    logic [7:0]  hex_sel;

    int tests  = 0;
    int failed = 0;

    int s_cnt    = 0;
    int s_idx    = 0;
    int disp_idx = 0;

    logic [6:0] dig_exp [8] = '{7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [7:0] exp_sel;

    hex_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata),
        .hex_led_o(hex_led),
        .hex_sel_o(hex_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; disp_idx is the digit the outputs show after this edge.
    task automatic tick();
        @(posedge clk);
        disp_idx = s_idx;
        if (rst) begin
            s_cnt = 0;
            s_idx = 0;
        end else if (req && we && addr[3:2] == 2'b10 && wdata[0]) begin
            s_cnt = 0;
            s_idx = 0;
        end else if (s_cnt == 3) begin
            s_cnt = 0;
            s_idx = (s_idx + 1) % 8;
        end else begin
            s_cnt++;
        end
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        req = 1'b0; we = 1'b0; wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [3:0] a);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 4'd0; wdata = 32'd0;

        // Reset and the basic scan
        tick();
        tick();
        check("rst_sel", {24'd0, hex_sel}, 32'hFF);
        check("rst_led", {25'd0, hex_led}, 32'h7F);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("slot0_sel_c%0d", i), {24'd0, hex_sel}, 32'hFE);
            check($sformatf("slot0_led_c%0d", i), {25'd0, hex_led}, 32'h40);
        end
        tick();
        check("slot1_sel", {24'd0, hex_sel}, 32'hFD);
        check("slot1_led", {25'd0, hex_led}, 32'h40);
        for (int i = 0; i < 24; i++) tick();
        check("slot7_sel", {24'd0, hex_sel}, 32'h7F);
        check("slot7_led", {25'd0, hex_led}, 32'h40);
        for (int i = 0; i < 4; i++) tick();
        check("wrap_sel", {24'd0, hex_sel}, 32'hFE);

        // DATA write, read-back and all sixteen-ish glyphs across one frame
        bus_write(4'h0, 32'hFEDC_BA98);
        bus_read(4'h0);
        check("data_read", rdata, 32'hFEDC_BA98);
        for (int i = 0; i < 32; i++) begin
            tick();
            exp_sel = ~(8'h01 << disp_idx);
            check($sformatf("data_led_d%0d", disp_idx), {25'd0, hex_led}, {25'd0, dig_exp[disp_idx]});
            check($sformatf("data_sel_d%0d", disp_idx), {24'd0, hex_sel}, {24'd0, exp_sel});
        end

        // MASK: only digits 0 and 2 lit
        bus_write(4'h4, 32'hFFFF_FF05);
        bus_read(4'h4);
        check("mask_read", rdata, 32'h0000_0005);
        for (int i = 0; i < 32; i++) begin
            tick();
            exp_sel = (disp_idx == 0) ? 8'hFE : (disp_idx == 2) ? 8'hFB : 8'hFF;
            check($sformatf("mask_sel_d%0d", disp_idx), {24'd0, hex_sel}, {24'd0, exp_sel});
        end

        // CTRL clear in the middle of slot 5
        bus_write(4'h0, 32'h1234_5678);
        bus_write(4'h4, 32'h0000_000F);
        for (int g = 0; g < 64 && s_idx != 5; g++) tick();
        bus_write(4'h8, 32'h0000_0001);
        tick();
        check("clr_sel", {24'd0, hex_sel}, 32'hFE);
        check("clr_led", {25'd0, hex_led}, 32'h40);
        bus_read(4'h0);
        check("clr_data", rdata, 32'd0);
        bus_read(4'h4);
        check("clr_mask", rdata, 32'hFF);

        // CTRL write with bit 0 clear does nothing
        bus_write(4'h0, 32'h0000_0055);
        bus_write(4'h8, 32'hFFFF_FFFE);
        bus_read(4'h0);
        check("ctrl0_data", rdata, 32'h0000_0055);

        // Ignored accesses
        bus_write(4'h4, 32'h0000_003C);
        bus_write(4'hC, 32'hFFFF_FFFF);
        bus_read(4'h0);
        check("resv_data", rdata, 32'h0000_0055);
        bus_read(4'h4);
        check("resv_mask", rdata, 32'h0000_003C);
        req = 1'b0; we = 1'b1; addr = 4'h0; wdata = 32'hDEAD_BEEF;
        tick();
        we = 1'b0; wdata = 32'd0;
        bus_read(4'h0);
        check("noreq_data", rdata, 32'h0000_0055);
        bus_read(4'h7);
        check("addr_lsb_ignored", rdata, 32'h0000_003C);
        bus_read(4'h8);
        check("read_ctrl", rdata, 32'd0);
        bus_read(4'h4);
        bus_read(4'hC);
        check("read_resv", rdata, 32'd0);
        bus_read(4'h0);
        for (int i = 0; i < 3; i++) tick();
        check("rdata_hold", rdata, 32'h0000_0055);

        // Reset overrides a concurrent write
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 4'h0; wdata = 32'hAAAA_AAAA;
        tick();
        check("rst_mid_sel", {24'd0, hex_sel}, 32'hFF);
        check("rst_mid_rdata", rdata, 32'd0);
        rst = 1'b0; req = 1'b0; we = 1'b0; wdata = 32'd0;
        tick();
        check("rst_mid_sel_after", {24'd0, hex_sel}, 32'hFE);
        bus_read(4'h0);
        check("rst_mid_data", rdata, 32'd0);
        bus_read(4'h4);
        check("rst_mid_mask", rdata, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Memory-mapped 8-digit seven-segment display controller on the data bus. It consumes the address decoder's HEX write strobe (`we_hex_o`, window 0x80001000–0x8000100F) and the core's request, write data and address. It holds a 32-bit digit register and an 8-bit digit-enable mask. It time-multiplexes the eight digits onto shared active-low segment and anode lines, and returns register contents on the read mux path selected by `RDSEL_HEX`.

## Interface
- `SCAN_DIV`, default 1024: clock cycles each digit stays lit. Legal range ≥ 2. Counter width is $clog2(SCAN_DIV).
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  bus request from the core.
- `we_i`  in  1  write strobe; driven from the decoder's `we_hex_o` (already gated with req and address).
- `addr_i`  in  4  byte offset within the HEX window (core addr[3:0]).
- `wdata_i`  in  32  write data.
- `rdata_o`  out  32  registered read data.
- `hex_led_o`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `hex_sel_o`  out  8  digit anodes, active-low; bit n drives digit n.

## Operation
- Register map; only `addr_i[3:2]` is decoded and `addr_i[1:0]` is ignored:
  - 0x0 DATA: digit n = `DATA[4n+3:4n]`.
  - 0x4 MASK: `[7:0]`, where 1 means digit enabled; upper bits read as 0.
  - 0x8 CTRL: write-only. Writing with `wdata_i[0]`=1 clears DATA to 0, sets MASK to 8'hFF, and restarts the scan. Reads return 0.
  - 0xC: reserved. Writes are ignored and reads return 0.
- Write: on a cycle with `req_i`=1 and `we_i`=1, the target register updates at that clock edge. Full-word writes only; no byte enables.
- Read: on a cycle with `req_i`=1 and `we_i`=0, `rdata_o` loads the selected register at that edge. `rdata_o` holds its value on all other cycles.
- `we_i`=1 with `req_i`=0 is ignored.
- Scan counter `cnt`:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and digit index `idx` (3-bit) increments, wrapping 7→0.
- Output register, updated every cycle:
  - `hex_sel_o` ← ~(MASK[idx] << idx).
  - `hex_led_o` ← seg(DATA nibble idx).
- Segment encoding, active-low gfedcba:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- A disabled digit (MASK bit 0) drives all anodes high for its whole slot. The slot still takes SCAN_DIV cycles, so brightness is uniform.

## Timing
- Reset values:
  - DATA=0, MASK=8'hFF, `cnt`=0, `idx`=0, `rdata_o`=0.
  - `hex_sel_o`=8'hFF and `hex_led_o`=7'h7F in the reset cycle.
- First cycle after reset release: `hex_sel_o`=8'hFE and `hex_led_o`=7'h40 (digit 0 shows "0").
- Read latency is 1 cycle: data is valid on the edge after the request cycle.
- Write-to-display latency is 1 cycle: the output register samples the new DATA/MASK on the edge after the write edge.
- Read of a register written in the same cycle returns the old value. Not reachable on this bus, since `we_i` distinguishes the two.
- CTRL clear:
  - `cnt` and `idx` reset to 0 at the write edge.
  - Next cycle: `hex_sel_o`=8'hFE, `hex_led_o`=7'h40.
  - A CTRL write with `wdata_i[0]`=0 has no effect.
- Digit slot length is exactly SCAN_DIV cycles. The full frame is 8·SCAN_DIV cycles.
- `rst_i` asserted mid-scan or mid-transaction overrides everything at that edge, including a concurrent write.

## Test plan
- Reset (SCAN_DIV=4):
  - Hold `rst_i` 2 cycles, then release.
  - Check `hex_sel_o`=FF and `hex_led_o`=7F during reset, then FE/40 for exactly 4 cycles.
  - Then FD/40, and digit 7 (7F/40) followed by a wrap to FE after 32 cycles.
- DATA write: write 0x0 ← 32'hFEDC_BA98, then read 0x0.
  - `rdata_o`=FEDCBA98 one cycle after the read.
  - Across the scan, digits 0..7 show 00, 10, 08, 03, 46, 21, 06, 0E.
- MASK: write 0x4 ← 32'hFFFF_FF05.
  - Read returns 00000005.
  - Only digit slots 0 and 2 drive a low anode (FE, FB); the other slots show FF.
- CTRL clear mid-scan: after DATA=12345678 and MASK=0F, wait until `idx`=5, then write 0x8 ← 1.
  - Next cycle: `hex_sel_o`=FE, `hex_led_o`=40.
  - DATA reads 0 and MASK reads FF.
- Ignored accesses:
  - Write 0xC ← FFFFFFFF: no register changes.
  - `we_i`=1 with `req_i`=0 to 0x0: DATA unchanged.
  - Read 0x8 and 0xC: both return 0.
  - With `req_i`=0, `rdata_o` holds its last value.
- Reset mid-write: assert `rst_i` in the same cycle as write 0x0 ← AAAAAAAA.
  - DATA reads 0 after reset.
